// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU. Optional perf counters under MC_CTRL_PERF_EN.
module mips_mc_ctrl #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int WAIT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       zext_imm,
    output logic       halted,
    output logic [1:0] err_code,
    output logic [3:0] state_dbg
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC+4 into PC on completion
    // DECODE | precompute branch target, dispatch on opcode
    // MEMADR | rs + imm into ALUOut for lw/sw
    // MEMRD  | data read at ALUOut
    // MEMWB  | MDR into rt
    // MEMWR  | data write at ALUOut
    // EXEC   | R-type ALU op selected by funct
    // ALUWB  | ALUOut into rd
    // BRANCH | beq compare, PC <= target if zero
    // JUMP   | PC <= jump target
    // IMMEX  | addi / ori ALU op
    // IMMWB  | ALUOut into rt
    // HALT   | trapped until reset, err_code tells why
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter value during the last permitted wait cycle; a miss here traps.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        err_q;
    logic              ori_q;

    logic              funct_ok;
    logic [2:0]        funct_alu;
    logic              mem_state;
    logic              wait_expired;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    assign mem_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            err_q    <= ERR_NONE;
            ori_q    <= 1'b0;
        end else begin
            // Only the memory states self-loop, so clearing elsewhere means
            // each memory state starts its wait from zero.
            if (mem_state && !mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state <= S_HALT;
                        err_q <= ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:       state <= S_EXEC;
                        OP_LW, OP_SW:   state <= S_MEMADR;
                        OP_BEQ:         state <= S_BRANCH;
                        OP_J:           state <= S_JUMP;
                        OP_ADDI, OP_ORI: state <= S_IMMEX;
                        default: begin
                            state <= S_HALT;
                            err_q <= ERR_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ready) begin
                        state <= S_MEMWB;
                    end else if (wait_expired) begin
                        state <= S_HALT;
                        err_q <= ERR_TIMEOUT;
                    end
                end
                S_MEMWB: state <= S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else if (wait_expired) begin
                        state <= S_HALT;
                        err_q <= ERR_TIMEOUT;
                    end
                end
                S_EXEC: begin
                    if (funct_ok) begin
                        state <= S_ALUWB;
                    end else begin
                        state <= S_HALT;
                        err_q <= ERR_ILLEGAL;
                    end
                end
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_IMMEX: begin
                    ori_q <= (opcode == OP_ORI);
                    state <= S_IMMWB;
                end
                S_IMMWB:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        instr_done;

    assign instr_done = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                        (state == S_JUMP)  || (state == S_IMMWB) ||
                        ((state == S_MEMWR) && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state != S_HALT) cycle_q <= cycle_q + 32'd1;
            if (instr_done)      instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_cnt = rst ? cycle_q : 32'd0;
    assign instr_cnt = rst ? instr_q : 32'd0;
`endif

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        pc_src     = 2'b00;
        zext_imm   = 1'b0;
        halted     = 1'b0;
        err_code   = ERR_NONE;
        state_dbg  = 4'd0;
        if (rst) begin
            state_dbg = state;
            err_code  = err_q;
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = funct_alu;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                S_IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                    zext_imm  = (opcode == OP_ORI);
                end
                S_IMMWB: begin
                    reg_write = 1'b1;
                    zext_imm  = ori_q;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: each instruction is expanded into its
// expected per-cycle phase sequence and compared cycle by cycle.
module tb_mips_mc_ctrl;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic alu_src_a, zext_imm, halted;
    logic [1:0] alu_src_b, pc_src, err_code;
    logic [2:0] alu_ctrl;
    logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_mc_ctrl #(.MEM_WAIT_MAX(MAXW), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .zext_imm(zext_imm), .halted(halted), .err_code(err_code),
        .state_dbg(state_dbg)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic zext_imm, halted;
        logic [1:0] err_code;
    } outs_t;

    typedef struct {
        string tag;
        logic [5:0] op;
        logic [5:0] fn;
        logic mr;
        logic zr;
        outs_t e;
        outs_t m;
        bit fin;
    } step_t;

    step_t plan[$];
    logic [5:0] cur_op, cur_fn;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_cyc = 0;
    int exp_instr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic outs_t get_obs();
        outs_t o;
        o.st = state_dbg; o.pc_en = pc_en; o.iord = iord; o.mem_read = mem_read;
        o.mem_write = mem_write; o.ir_write = ir_write; o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.reg_write = reg_write; o.alu_src_a = alu_src_a;
        o.alu_src_b = alu_src_b; o.alu_ctrl = alu_ctrl; o.pc_src = pc_src;
        o.zext_imm = zext_imm; o.halted = halted; o.err_code = err_code;
        return o;
    endfunction

    function automatic outs_t ph(input int st);
        outs_t o = '0;
        o.st = st[3:0];
        return o;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic add(input string tag, input logic mr, input logic zr, input outs_t e,
                       input bit fin = 0, input bit dc_alu = 0);
        step_t s;
        s.tag = tag; s.op = cur_op; s.fn = cur_fn; s.mr = mr; s.zr = zr;
        s.e = e; s.m = '1; s.fin = fin;
        if (dc_alu) s.m.alu_ctrl = '0;
        plan.push_back(s);
    endtask

    task automatic push_halt(input logic [1:0] err, input int n);
        outs_t o = ph(15);
        o.halted = 1'b1;
        o.err_code = err;
        for (int i = 0; i < n; i++) add("halt", rb(), rb(), o);
    endtask

    // kind: 0 add,1 sub,2 and,3 or,4 slt,5 lw,6 sw,7 beq,8 j,9 addi,10 ori,
    // 11 illegal opcode, 12 illegal funct. wf/wm: mem_ready-low cycles in fetch/data.
    task automatic plan_instr(input int kind, input int wf, input int wm, input logic zr,
                              input int nhalt = 3);
        outs_t o;
        logic [2:0] ralu;
        case (kind)
            0: begin cur_op = 6'b000000; cur_fn = 6'b100000; ralu = 3'b010; end
            1: begin cur_op = 6'b000000; cur_fn = 6'b100010; ralu = 3'b110; end
            2: begin cur_op = 6'b000000; cur_fn = 6'b100100; ralu = 3'b000; end
            3: begin cur_op = 6'b000000; cur_fn = 6'b100101; ralu = 3'b001; end
            4: begin cur_op = 6'b000000; cur_fn = 6'b101010; ralu = 3'b111; end
            5: begin cur_op = 6'b100011; cur_fn = 6'($urandom); ralu = 3'b000; end
            6: begin cur_op = 6'b101011; cur_fn = 6'($urandom); ralu = 3'b000; end
            7: begin cur_op = 6'b000100; cur_fn = 6'($urandom); ralu = 3'b000; end
            8: begin cur_op = 6'b000010; cur_fn = 6'($urandom); ralu = 3'b000; end
            9: begin cur_op = 6'b001000; cur_fn = 6'($urandom); ralu = 3'b000; end
            10: begin cur_op = 6'b001101; cur_fn = 6'($urandom); ralu = 3'b000; end
            11: begin
                cur_fn = 6'($urandom); ralu = 3'b000;
                do cur_op = 6'($urandom);
                while (cur_op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                      6'b000010, 6'b001000, 6'b001101});
            end
            default: begin
                cur_op = 6'b000000; ralu = 3'b000;
                do cur_fn = 6'($urandom);
                while (cur_fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
            end
        endcase

        o = ph(0); o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
        for (int i = 0; i < wf && i < MAXW; i++) add("fetch_wait", 1'b0, rb(), o);
        if (wf >= MAXW) begin
            push_halt(2'b10, nhalt);
            return;
        end
        o.ir_write = 1'b1; o.pc_en = 1'b1;
        add("fetch", 1'b1, rb(), o);

        o = ph(1); o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010;
        add("decode", rb(), rb(), o);

        case (kind)
            0, 1, 2, 3, 4: begin
                o = ph(6); o.alu_src_a = 1'b1; o.alu_ctrl = ralu;
                add("exec", rb(), rb(), o);
                o = ph(7); o.reg_write = 1'b1; o.reg_dst = 1'b1;
                add("aluwb", rb(), rb(), o, 1);
            end
            5, 6: begin
                o = ph(2); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010;
                add("memadr", rb(), rb(), o);
                o = ph(kind == 5 ? 3 : 5); o.iord = 1'b1;
                if (kind == 5) o.mem_read = 1'b1; else o.mem_write = 1'b1;
                for (int i = 0; i < wm && i < MAXW; i++) add("mem_wait", 1'b0, rb(), o);
                if (wm >= MAXW) begin
                    push_halt(2'b10, nhalt);
                    return;
                end
                add(kind == 5 ? "memrd" : "memwr", 1'b1, rb(), o, kind == 6);
                if (kind == 5) begin
                    o = ph(4); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                    add("memwb", rb(), rb(), o, 1);
                end
            end
            7: begin
                o = ph(8); o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
                o.pc_en = zr;
                add("branch", rb(), zr, o, 1);
            end
            8: begin
                o = ph(9); o.pc_src = 2'b10; o.pc_en = 1'b1;
                add("jump", rb(), rb(), o, 1);
            end
            9, 10: begin
                o = ph(10); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_ctrl = (kind == 10) ? 3'b001 : 3'b010; o.zext_imm = (kind == 10);
                add("immex", rb(), rb(), o);
                o = ph(11); o.reg_write = 1'b1; o.zext_imm = (kind == 10);
                add("immwb", rb(), rb(), o, 1);
            end
            11: push_halt(2'b01, nhalt);
            default: begin
                o = ph(6); o.alu_src_a = 1'b1;
                add("exec_bad", rb(), rb(), o, 0, 1);
                push_halt(2'b01, nhalt);
            end
        endcase
    endtask

    task automatic run_plan();
        step_t s;
        outs_t o;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            rst = 1'b1; opcode = s.op; funct = s.fn; mem_ready = s.mr; zero = s.zr;
            #1;
            o = get_obs();
            check(s.tag, 32'(o & s.m), 32'(s.e & s.m));
`ifdef MC_CTRL_PERF_EN
            check("cycle_cnt", cycle_cnt, 32'(exp_cyc));
            check("instr_cnt", instr_cnt, 32'(exp_instr));
`endif
            if (s.e.st != 4'd15) exp_cyc++;
            if (s.fin) exp_instr++;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = rb();
        zero = 1'b1;
        #1;
        check("rst_outs", 32'(get_obs()), 32'd0);
`ifdef MC_CTRL_PERF_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instr_cnt", instr_cnt, 32'd0);
`endif
        repeat (n) @(posedge clk);
        exp_cyc = 0;
        exp_instr = 0;
    endtask

    initial begin
        do_reset(2);

        // add, lw with three stalled data cycles, beq taken then not taken
        plan_instr(0, 0, 0, 1'b0);
        plan_instr(5, 0, 3, 1'b0);
        plan_instr(7, 0, 0, 1'b1);
        plan_instr(7, 0, 0, 1'b0);
        run_plan();

        // add, sw, j from reset: instruction count ends at 3
        do_reset(1);
        plan_instr(0, 0, 0, 1'b0);
        plan_instr(6, 0, 0, 1'b0);
        plan_instr(8, 0, 0, 1'b0);
        run_plan();
`ifdef MC_CTRL_PERF_EN
        check("instr_cnt_3", instr_cnt, 32'(exp_instr));
        check("instr_cnt_3_abs", instr_cnt, 32'd3);
`endif

        do_reset(1);
        repeat (60) begin
            plan_instr($urandom_range(0, 10), $urandom_range(0, MAXW - 1),
                       $urandom_range(0, MAXW - 1), rb());
            run_plan();
        end

        // illegal opcode parks in HALT until reset clears the error
        plan_instr(11, 0, 0, 1'b0, 20);
        run_plan();
        do_reset(1);
        plan_instr(0, 0, 0, 1'b0);
        run_plan();

        plan_instr(12, 0, 0, 1'b0);
        run_plan();
        do_reset(1);

        // fetch timeout, then completion on the last permitted wait cycle
        plan_instr(0, MAXW, 0, 1'b0);
        run_plan();
        do_reset(1);
        plan_instr(9, MAXW - 1, 0, 1'b0);
        plan_instr(10, 0, 0, 1'b0);
        run_plan();

        // data read timeout
        plan_instr(5, 0, MAXW, 1'b0);
        run_plan();
        do_reset(1);

        // reset arriving while a store waits in MEMWR
        plan_instr(6, 0, 2, 1'b0);
        void'(plan.pop_back());
        run_plan();
        mem_ready = 1'b0;
        do_reset(1);
        plan_instr(3, 0, 0, 1'b0);
        run_plan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the team's MIPS core; replaces single-cycle decode when the datapath shares one memory port and one ALU across cycles.
- Moore FSM sequences fetch/decode/execute/memory/writeback per instruction.
- Drives datapath muxes and enables; handshakes with memory via mem_ready.
- Traps illegal opcodes and memory timeouts into a HALT state.

Parameters:
- MEM_WAIT_MAX, 255, max cycles any memory state waits for mem_ready before error; legal range 1..255.
- WAIT_W, 8, width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC write enable
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- zext_imm  out  1  selects zero-extended imm for ORI
- halted  out  1  FSM in HALT
- err_code  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: rst=0 at a rising edge → state=FETCH, wait_cnt=0, err_code=00. All outputs are forced to 0 combinationally while rst=0. Reset overrides every state, including mid-wait and HALT.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, HALT=15.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - ir_write=1 and pc_en=1 only in the cycle mem_ready=1; that cycle → DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011 lw, 101011 sw → MEMADR
  - 000100 beq → BRANCH
  - 000010 j → JUMP
  - 001000 addi, 001101 ori → IMMEX
  - any other opcode → HALT with err 01
- MEMADR: alu_src_a=1, alu_src_b=10, ADD → MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1; wait for mem_ready → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: iord=1, mem_write=1; wait for mem_ready → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT
  - any other funct → HALT with err 01, no writeback
  - legal funct → ALUWB
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; pc_en=zero (combinational from the zero input) → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10; ADD for addi; OR with zext_imm=1 for ori → IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; zext_imm holds its IMMEX value → IMMWB goes to FETCH.
- HALT: every strobe and enable is 0, halted=1, err_code holds its value; the FSM leaves HALT only on reset.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entering the state; increments each cycle mem_ready=0.
  - When wait_cnt reaches MEM_WAIT_MAX with mem_ready still 0 → HALT, err 10.
  - If mem_ready=1 arrives in the same cycle as the limit, completion wins.
- Cycles per instruction with mem_ready tied to 1:
  - lw 5; sw, R-type, addi, ori 4; beq, j 3.
- Strobes and enables not listed for a state are 0; mux selects not listed are don't-care and are driven to 0.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined: two extra outputs, cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every non-reset cycle not in HALT.
  - instr_cnt increments on each transition into FETCH from a completing state.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- mem_ready=1, rst held 0 for 2 cycles, then add (op 0, funct 100000) → FETCH,DECODE,EXEC,ALUWB; alu_ctrl=010 in EXEC; reg_write=1, reg_dst=1 in ALUWB; back in FETCH on cycle 5.
- lw with mem_ready low 3 cycles in MEMRD → MEMRD holds 4 cycles, mem_read=1 and iord=1 throughout; MEMWB has reg_write=1, mem_to_reg=1.
- beq with zero=1, then zero=0 → pc_en=1, pc_src=01 in BRANCH for the first; pc_en=0 for the second; each takes 3 cycles.
- Opcode 111111 → HALT after DECODE, halted=1, err_code=01; stays halted 20 cycles; rst=0 for 1 cycle → FETCH, err_code=00.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH → HALT after 4 wait cycles, err_code=10; repeat with mem_ready=1 on the 4th wait cycle → DECODE, no error.
- rst=0 asserted during MEMWR → next cycle state_dbg=0; mem_write is 0 during reset; with MC_CTRL_PERF_EN defined, instr_cnt=0 after reset and 3 after add, sw, j complete.
